// File: rtl/fp7pe_seq_ctrl.sv
// Sequencer for one fp7 dot-product PE: admits operand beats per scale group and
// times the int-acc clear, scale capture and fp32 accumulate strobes around the pipeline.
module fp7pe_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int ACC1_LAT = 2,
  parameter int TREE_LAT = 4,
  parameter int ACC2_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_beats,
  input  logic [CNT_W-1:0] cmd_groups,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             pe_op_en,
  output logic             pe_acc1_clr,
  output logic             pe_scale_en,
  output logic [CNT_W-1:0] pe_grp_idx,
  output logic             pe_acc2_clr,
  output logic             pe_acc2_en,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             busy
);

  localparam int FLUSH_W = $clog2(ACC1_LAT + 1);
  localparam int DRAIN_W = $clog2(TREE_LAT + ACC2_LAT + 1);
  localparam logic [FLUSH_W-1:0] FLUSH_INIT = FLUSH_W'(ACC1_LAT - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(TREE_LAT + ACC2_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   beats_m1_q;
  logic [CNT_W-1:0]   groups_m1_q;
  logic [CNT_W-1:0]   beat_cnt_q;
  logic [CNT_W-1:0]   grp_cnt_q;
  logic [FLUSH_W-1:0] flush_cnt_q;
  logic [DRAIN_W-1:0] drain_cnt_q;
  logic [TREE_LAT-1:0] acc2_sr_q;

  logic cmd_accept;
  logic flush_last;

  // cmd_ready is gated by rst so every output reads 0 while reset is asserted.
  assign cmd_ready   = rst & (state_q == S_IDLE);
  assign cmd_accept  = cmd_valid & cmd_ready;
  assign in_ready    = (state_q == S_STREAM);
  assign pe_op_en    = in_valid & in_ready;
  assign flush_last  = (state_q == S_FLUSH) && (flush_cnt_q == '0);

  assign pe_scale_en = flush_last;
  assign pe_grp_idx  = flush_last ? grp_cnt_q : '0;
  assign pe_acc1_clr = cmd_accept | flush_last;
  assign pe_acc2_clr = cmd_accept;
  assign pe_acc2_en  = acc2_sr_q[TREE_LAT-1];
  assign res_valid   = (state_q == S_DONE);
  assign busy        = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      beats_m1_q  <= '0;
      groups_m1_q <= '0;
      beat_cnt_q  <= '0;
      grp_cnt_q   <= '0;
      flush_cnt_q <= '0;
      drain_cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            beats_m1_q  <= cmd_beats;
            groups_m1_q <= cmd_groups;
            beat_cnt_q  <= '0;
            grp_cnt_q   <= '0;
            state_q     <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (in_valid) begin
            if (beat_cnt_q == beats_m1_q) begin
              flush_cnt_q <= FLUSH_INIT;
              state_q     <= S_FLUSH;
            end else begin
              beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
          end
        end
        S_FLUSH: begin
          // The last flush cycle is the scale capture; counters compare against minus-one values so they never wrap.
          if (flush_cnt_q == '0) begin
            if (grp_cnt_q == groups_m1_q) begin
              drain_cnt_q <= DRAIN_INIT;
              state_q     <= S_DRAIN;
            end else begin
              grp_cnt_q  <= grp_cnt_q + CNT_W'(1);
              beat_cnt_q <= '0;
              state_q    <= S_STREAM;
            end
          end else begin
            flush_cnt_q <= flush_cnt_q - FLUSH_W'(1);
          end
        end
        S_DRAIN: begin
          if (drain_cnt_q == '0) begin
            state_q <= S_DONE;
          end else begin
            drain_cnt_q <= drain_cnt_q - DRAIN_W'(1);
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Tracks each scale capture through the add tree so the fp32 add lands on the settled sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc2_sr_q <= '0;
    end else begin
      acc2_sr_q[0] <= pe_scale_en;
      for (int i = 1; i < TREE_LAT; i++) begin
        acc2_sr_q[i] <= acc2_sr_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_fp7pe_seq_ctrl.sv
// Self-checking bench for fp7pe_seq_ctrl: table of tile commands with a scoreboard of
// expected strobe cycles, plus a hand-written asynchronous reset sequence.
module tb_fp7pe_seq_ctrl;

  localparam int CNT_W    = 8;
  localparam int ACC1_LAT = 2;
  localparam int TREE_LAT = 4;
  localparam int ACC2_LAT = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_beats = '0;
  logic [CNT_W-1:0] cmd_groups = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             pe_op_en;
  logic             pe_acc1_clr;
  logic             pe_scale_en;
  logic [CNT_W-1:0] pe_grp_idx;
  logic             pe_acc2_clr;
  logic             pe_acc2_en;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic             busy;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    int beatsM1;
    int groupsM1;
    int stallStart;
    int stallLen;
    int hold;
    int spam;
    int expRes;
  } vec_t;

  vec_t vecs[7];

  fp7pe_seq_ctrl #(
    .CNT_W(CNT_W), .ACC1_LAT(ACC1_LAT), .TREE_LAT(TREE_LAT), .ACC2_LAT(ACC2_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_beats(cmd_beats), .cmd_groups(cmd_groups),
    .in_valid(in_valid), .in_ready(in_ready),
    .pe_op_en(pe_op_en), .pe_acc1_clr(pe_acc1_clr),
    .pe_scale_en(pe_scale_en), .pe_grp_idx(pe_grp_idx),
    .pe_acc2_clr(pe_acc2_clr), .pe_acc2_en(pe_acc2_en),
    .res_valid(res_valid), .res_ready(res_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One tile: expected strobe cycles go onto queues as the command is issued and are popped as the DUT raises them.
  task automatic applyStimulus(input vec_t v, input string tag);
    int B, G, period, cyc, beatsSeen, readyErr, holdErr, resSeen, doneCyc;
    int s, e;
    bit finished, expIn;
    int scaleQ[$];
    int grpQ[$];
    int acc2Q[$];
    B = v.beatsM1 + 1;
    G = v.groupsM1 + 1;
    period = B + ACC1_LAT;
    beatsSeen = 0; readyErr = 0; holdErr = 0; resSeen = -1; doneCyc = -1;
    for (int g = 0; g < G; g++) begin
      scaleQ.push_back((g + 1) * period + v.stallLen);
      grpQ.push_back(g);
      acc2Q.push_back((g + 1) * period + v.stallLen + TREE_LAT);
    end

    @(posedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_beats  = CNT_W'(v.beatsM1);
    cmd_groups = CNT_W'(v.groupsM1);
    in_valid   = 1'b1;
    res_ready  = (v.hold == 0);
    @(negedge clk);
    checkOutput({tag, " accept cmd_ready"}, 32'(cmd_ready), 1);
    checkOutput({tag, " accept clears"}, 32'({pe_acc1_clr, pe_acc2_clr}), 3);

    cyc = 0;
    finished = 0;
    while (!finished) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > v.expRes + v.hold + 20) begin
        checkOutput({tag, " timeout waiting for result"}, 32'(cyc), 32'(v.expRes));
        break;
      end
      cmd_valid = (v.spam != 0);
      in_valid  = !(cyc >= v.stallStart && cyc < v.stallStart + v.stallLen);
      if (v.hold == 0) res_ready = 1'b1;
      else res_ready = (resSeen >= 0) && (cyc >= resSeen + v.hold);
      @(negedge clk);

      if (cyc == 1) checkOutput({tag, " busy"}, 32'(busy), 1);
      expIn = 0;
      for (int g = 0; g < G; g++) begin
        s = g * period + 1 + ((g > 0) ? v.stallLen : 0);
        e = g * period + B + v.stallLen;
        if (cyc >= s && cyc <= e) expIn = 1;
      end
      if (in_ready !== expIn) readyErr++;
      if (pe_op_en === 1'b1) beatsSeen++;

      if (pe_scale_en === 1'b1) begin
        if (scaleQ.size() == 0) checkOutput({tag, " unexpected scale_en"}, 32'(cyc), 0);
        else begin
          checkOutput({tag, " scale_en cycle"}, 32'(cyc), 32'(scaleQ.pop_front()));
          checkOutput({tag, " grp_idx"}, 32'(pe_grp_idx), 32'(grpQ.pop_front()));
          checkOutput({tag, " acc1_clr with scale"}, 32'(pe_acc1_clr), 1);
        end
      end
      if (pe_acc2_en === 1'b1) begin
        if (acc2Q.size() == 0) checkOutput({tag, " unexpected acc2_en"}, 32'(cyc), 0);
        else checkOutput({tag, " acc2_en cycle"}, 32'(cyc), 32'(acc2Q.pop_front()));
      end
      if (res_valid === 1'b1) begin
        if (resSeen < 0) begin
          resSeen = cyc;
          checkOutput({tag, " res_valid cycle"}, 32'(cyc), 32'(v.expRes));
        end
        if (cmd_ready !== 1'b0) holdErr++;
        if (res_ready) begin
          doneCyc = cyc;
          finished = 1;
        end
      end
    end

    checkOutput({tag, " in_ready window errors"}, 32'(readyErr), 0);
    checkOutput({tag, " operand beats"}, 32'(beatsSeen), 32'(B * G));
    checkOutput({tag, " leftover strobes"}, 32'(scaleQ.size() + acc2Q.size()), 0);
    checkOutput({tag, " cmd_ready while done"}, 32'(holdErr), 0);
    if (v.hold > 0) checkOutput({tag, " held result cycles"}, 32'(doneCyc - resSeen), 32'(v.hold));

    @(posedge clk); #1;
    cmd_valid = 1'b0;
    in_valid  = 1'b0;
    res_ready = 1'b0;
    @(negedge clk);
    checkOutput({tag, " idle after result"}, 32'({cmd_ready, busy, res_valid}), 32'(3'b100));
  endtask

  initial begin
    // beatsM1, groupsM1, stallStart, stallLen, hold, spam, expRes
    vecs[0] = '{3,   1, 0, 0, 0, 0, 19};
    vecs[1] = '{0,   0, 0, 0, 0, 0, 10};
    vecs[2] = '{3,   1, 2, 2, 0, 0, 21};
    vecs[3] = '{3,   1, 0, 0, 5, 1, 19};
    vecs[4] = '{255, 1, 0, 0, 0, 0, 523};
    vecs[5] = '{1,   2, 2, 1, 2, 1, 20};
    vecs[6] = '{0,   3, 0, 0, 0, 0, 19};

    #1;
    checkOutput("in reset outputs", 32'({cmd_ready, busy, res_valid, pe_acc2_en, in_ready}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("after reset cmd_ready", 32'(cmd_ready), 1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset asserted between edges in the scale cycle of group 0 must clear everything at once.
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_beats = 8'd3; cmd_groups = 8'd1; in_valid = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    #1;
    checkOutput("pre-reset scale_en", 32'(pe_scale_en), 1);
    rst = 1'b0;
    #1;
    checkOutput("async reset outputs", 32'({cmd_ready, in_ready, pe_op_en, pe_acc1_clr, pe_scale_en,
                pe_grp_idx, pe_acc2_clr, pe_acc2_en, res_valid, busy}), 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    begin
      int stray;
      stray = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (pe_acc2_en !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) stray++;
      end
      checkOutput("no stray strobes after reset", 32'(stray), 0);
    end
    applyStimulus('{1, 0, 0, 0, 0, 0, 11}, "post-reset");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
